// File: rtl/prio_arb_mux_pkg.sv
// Shared types and helpers for the N-channel arbitrating multiplexer.
// Imported by the arbiter and the top level.
package prio_arb_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/prio_arbiter.sv
// Combinational fixed-priority / round-robin arbiter built on a
// double-width masked priority encoder.
module prio_arbiter
    import prio_arb_mux_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int RR_MODE = 0,
    parameter int CH_W    = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_any
);

    localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic [N_CH-1:0]   mask;
    logic [2*N_CH-1:0] dbl;
    int                pos;
    int                idx;

    // Keep only requests at or above the pointer; all of them in fixed mode.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            mask[i] = (MODE == ARB_FIXED) || (i >= int'(ptr));
        end
    end

    // Lowest set bit of {req, masked req} is the next requester, wrapping.
    always_comb begin
        dbl = {req, req & mask};
        pos = 0;
        for (int i = 2*N_CH-1; i >= 0; i--) begin
            if (dbl[i]) pos = i;
        end
        idx        = (pos >= N_CH) ? pos - N_CH : pos;
        gnt_any    = |req;
        gnt_idx    = CH_W'(idx);
        gnt_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt_onehot[i] = gnt_any && (idx == i);
        end
    end

endmodule

// File: rtl/prio_arb_mux.sv
// Registered N-channel arbitrating multiplexer with valid/ready on both
// sides; one output register stage, one word per cycle sustained.
module prio_arb_mux
    import prio_arb_mux_pkg::*;
#(
    parameter int  N_CH    = 4,
    parameter int  W       = 8,
    parameter int  RR_MODE = 0,
    localparam int CH_W    = clog2_min1(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    input  logic              out_ready
);

    localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);

    logic              load_en;
    logic              xfer;
    logic [N_CH-1:0]   gnt_onehot;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [CH_W-1:0]   rr_ptr;
    logic [W-1:0]      sel_data;

    assign load_en = !out_valid || out_ready;

    prio_arbiter #(
        .N_CH    (N_CH),
        .RR_MODE (RR_MODE),
        .CH_W    (CH_W)
    ) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign in_ready = gnt_onehot & {N_CH{load_en}};
    assign xfer     = gnt_any && load_en;

    // AND-OR mux so unselected channel data can never leak to the output.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_data = sel_data | (in_data[i*W +: W] & {W{gnt_onehot[i]}});
        end
    end

    // Output register: load on transfer, drop valid on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves past the channel that just transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if ((RR_MODE != 0) && xfer) begin
            rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + CH_W'(1);
        end
    end

endmodule

// File: tb/tb_prio_arb_mux.sv
// Self-checking bench: fixed-priority and round-robin instances driven
// from shared stimulus, expected words queued and compared on output.
module tb_prio_arb_mux;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  fx_in_ready;
    logic        fx_out_valid;
    logic [7:0]  fx_out_data;
    logic [1:0]  fx_out_ch;

    logic [3:0]  rr_in_ready;
    logic        rr_out_valid;
    logic [7:0]  rr_out_data;
    logic [1:0]  rr_out_ch;

    int   checks;
    int   failures;
    exp_t exp_fx[$];
    exp_t exp_rr[$];
    int   mptr;

    prio_arb_mux #(.N_CH(4), .W(8), .RR_MODE(0)) dut_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (fx_in_ready),
        .out_valid (fx_out_valid),
        .out_data  (fx_out_data),
        .out_ch    (fx_out_ch),
        .out_ready (out_ready)
    );

    prio_arb_mux #(.N_CH(4), .W(8), .RR_MODE(1)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rr_in_ready),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_ch    (rr_out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_gnt(bit rr, logic [3:0] v, int ptr);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = rr ? (ptr + k) % 4 : k;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot4(int g);
        logic [3:0] r;
        r = 4'b0000;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        exp_fx.delete();
        exp_rr.delete();
        mptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (fx_out_valid !== 1'b0 || fx_out_data !== 8'h00 || fx_out_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset_fx got v=%b d=%h ch=%0d want 0/00/0",
                     fx_out_valid, fx_out_data, fx_out_ch);
        end
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset_rr got v=%b d=%h ch=%0d want 0/00/0",
                     rr_out_valid, rr_out_data, rr_out_ch);
        end
        checks++;
        if (fx_in_ready !== 4'b0000 || rr_in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got fx=%b rr=%b want 0000", fx_in_ready, rr_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        int   g;
        do_reset();
        in_data   = 32'h33_00_11_00;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            g = model_gnt(1'b0, in_valid, 0);
            checks++;
            if (fx_in_ready !== onehot4(g)) begin
                failures++;
                $display("FAIL fixed_ready c=%0d got %b want %b", c, fx_in_ready, onehot4(g));
            end
            e.ch = 2'(g);
            e.data = in_data[g*8 +: 8];
            exp_fx.push_back(e);
            @(posedge clk);
            #1;
            e = exp_fx.pop_front();
            checks++;
            if (fx_out_valid !== 1'b1 || fx_out_data !== e.data || fx_out_ch !== e.ch) begin
                failures++;
                $display("FAIL fixed_out c=%0d got v=%b d=%h ch=%0d want 1/%h/%0d",
                         c, fx_out_valid, fx_out_data, fx_out_ch, e.data, e.ch);
            end
            @(negedge clk);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   g;
        do_reset();
        in_data   = 32'h43_42_41_40;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            g = model_gnt(1'b1, in_valid, mptr);
            checks++;
            if (rr_in_ready !== onehot4(g) || !$onehot(rr_in_ready)) begin
                failures++;
                $display("FAIL rr_ready c=%0d got %b want %b", c, rr_in_ready, onehot4(g));
            end
            e.ch = 2'(g);
            e.data = in_data[g*8 +: 8];
            exp_rr.push_back(e);
            mptr = (g + 1) % 4;
            @(posedge clk);
            #1;
            e = exp_rr.pop_front();
            checks++;
            if (rr_out_valid !== 1'b1 || rr_out_data !== e.data || rr_out_ch !== e.ch
                || rr_out_ch !== 2'(c % 4)) begin
                failures++;
                $display("FAIL rr_out c=%0d got v=%b d=%h ch=%0d want 1/%h/%0d",
                         c, rr_out_valid, rr_out_data, rr_out_ch, e.data, e.ch);
            end
            @(negedge clk);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        in_data   = 32'h00_A5_00_5A;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        e.ch = 2'd2;
        e.data = 8'hA5;
        exp_fx.push_back(e);
        @(posedge clk);
        #1;
        e = exp_fx.pop_front();
        checks++;
        if (fx_out_valid !== 1'b1 || fx_out_data !== e.data || fx_out_ch !== e.ch) begin
            failures++;
            $display("FAIL bp_load got v=%b d=%h ch=%0d want 1/%h/%0d",
                     fx_out_valid, fx_out_data, fx_out_ch, e.data, e.ch);
        end
        @(negedge clk);
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (fx_in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_ready c=%0d got %b want 0000", c, fx_in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (fx_out_valid !== 1'b1 || fx_out_data !== 8'hA5 || fx_out_ch !== 2'd2) begin
                failures++;
                $display("FAIL bp_hold c=%0d got v=%b d=%h ch=%0d want 1/a5/2",
                         c, fx_out_valid, fx_out_data, fx_out_ch);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (fx_in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_release_ready got %b want 0001", fx_in_ready);
        end
        e.ch = 2'd0;
        e.data = 8'h5A;
        exp_fx.push_back(e);
        @(posedge clk);
        #1;
        e = exp_fx.pop_front();
        checks++;
        if (fx_out_valid !== 1'b1 || fx_out_data !== e.data || fx_out_ch !== e.ch) begin
            failures++;
            $display("FAIL bp_release_out got v=%b d=%h ch=%0d want 1/%h/%0d",
                     fx_out_valid, fx_out_data, fx_out_ch, e.data, e.ch);
        end
        @(negedge clk);
        in_valid = 4'b0000;
    endtask

    task automatic test_rr_wrap();
        do_reset();
        in_data   = 32'hD3_C2_B1_A0;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut_rr.rr_ptr !== 2'd3 || rr_out_ch !== 2'd2) begin
            failures++;
            $display("FAIL wrap_ptr3 got ptr=%0d ch=%0d want 3/2", dut_rr.rr_ptr, rr_out_ch);
        end
        @(negedge clk);
        in_valid = 4'b0011;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_ready got %b want 0001", rr_in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_rr.rr_ptr !== 2'd1 || rr_out_ch !== 2'd0 || rr_out_data !== 8'hA0) begin
            failures++;
            $display("FAIL wrap_out got ptr=%0d ch=%0d d=%h want 1/0/a0",
                     dut_rr.rr_ptr, rr_out_ch, rr_out_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rr_in_ready !== 4'b0010) begin
            failures++;
            $display("FAIL wrap_next_ready got %b want 0010", rr_in_ready);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_data   = 32'h04_03_02_01;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== 2'd1) begin
            failures++;
            $display("FAIL arst_pre got v=%b ch=%0d want 1/1", rr_out_valid, rr_out_ch);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_ch !== 2'd0) begin
            failures++;
            $display("FAIL arst_clear got v=%b d=%h ch=%0d want 0/00/0",
                     rr_out_valid, rr_out_data, rr_out_ch);
        end
        exp_rr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL arst_first_ready got %b want 0001", rr_in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== 2'd0 || rr_out_data !== 8'h01) begin
            failures++;
            $display("FAIL arst_first_out got v=%b ch=%0d d=%h want 1/0/01",
                     rr_out_valid, rr_out_ch, rr_out_data);
        end
        @(negedge clk);
        in_valid = 4'b0000;
    endtask

    task automatic test_drain();
        do_reset();
        in_data   = 32'h5C_00_00_00;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (fx_out_valid !== 1'b1 || fx_out_data !== 8'h5C || fx_out_ch !== 2'd3) begin
            failures++;
            $display("FAIL drain_load got v=%b d=%h ch=%0d want 1/5c/3",
                     fx_out_valid, fx_out_data, fx_out_ch);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        checks++;
        if (fx_in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL drain_ready got %b want 0000", fx_in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fx_out_valid !== 1'b0 || fx_out_data !== 8'h5C || fx_out_ch !== 2'd3) begin
            failures++;
            $display("FAIL drain_out got v=%b d=%h ch=%0d want 0/5c/3",
                     fx_out_valid, fx_out_data, fx_out_ch);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        mptr      = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = 32'h0;
        out_ready = 1'b1;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_rr_wrap();
        test_async_reset();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
